counter_scheduler: RTL and testbench

Time-shares one CW-bit interval counter between NREQ requesters. Each requester asks for a run of a programmable length. The block arbitrates round-robin, sequences the counter for exactly that many cycles, then returns a one-cycle completion pulse to the granted requester. It sits between client logic (timers, pacing FSMs) and the counter datapath, and replaces per-client counters.

---
 rtl/counter_scheduler_pkg.sv | 16 +
 rtl/counter_scheduler_rr_arbiter.sv | 38 +++
 rtl/counter_scheduler.sv | 134 +++++++++++++
 tb/tb_counter_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_scheduler_pkg.sv
// Shared definitions for the counter scheduler.
//   state_t   : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   DEF_NREQ  : default number of requesters
//   DEF_CW    : default counter width in bits
package counter_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_NREQ = 4;
  localparam int DEF_CW   = 4;

endpackage

// File: rtl/counter_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans req upward starting at ptr, wrapping at NREQ, and returns the first
// set bit as a one-hot winner (all zeros when req is zero).
// Ports:
//   req [NREQ-1:0] : request levels
//   ptr [PW-1:0]   : index with highest priority (always < NREQ)
//   win [NREQ-1:0] : one-hot winner
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      // One extra bit holds ptr+i before the modulo-NREQ fold.
      sum = {1'b0, ptr} + (PW + 1)'(i);
      if (sum >= (PW + 1)'(NREQ)) sum = sum - (PW + 1)'(NREQ);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// Time-shares one CW-bit interval counter between NREQ requesters.
// A requester holds req[i] with its run length on len[i*CW +: CW]; the block
// grants round-robin, counts 0..L-1 (L = len, or 2^CW when len is 0), then
// pulses done[i] for one cycle. Dropping req[i] during the run aborts it.
// Ports:
//   clock     : rising-edge clock
//   reset     : synchronous, active-high reset
//   req       : per-requester request levels, held for the whole run
//   len       : packed run lengths, requester i at [i*CW +: CW]
//   gnt       : one-hot grant, RUN entry through the DONE cycle
//   done      : one-hot one-cycle completion pulse (DONE state only)
//   busy      : high in RUN and DONE
//   count_out : counter value of the active run
//   state_dbg : current FSM state (state_t encoding)
//
// Handshake: a request is a level; it is accepted in the IDLE cycle in which
// it wins arbitration and must stay high until done is seen, otherwise the
// run is aborted without a done pulse.
module counter_scheduler
  import counter_scheduler_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int CW   = DEF_CW,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic [CW-1:0]      count_out,
  output logic [1:0]         state_dbg
);

  state_t        state;
  logic [CW-1:0] tlen;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;

  logic [NREQ-1:0] win;
  logic [PW-1:0]   win_idx;
  logic [CW-1:0]   win_len;
  logic [PW-1:0]   ptr_next;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req),
    .ptr (ptr),
    .win (win)
  );

  // Index and run length of the arbitration winner.
  always_comb begin
    win_idx = '0;
    win_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        win_idx = PW'(i);
        win_len = len[i*CW +: CW];
      end
    end
  end

  // Priority moves to the requester after the one just served.
  assign ptr_next = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);

  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      count_out <= '0;
      tlen      <= '0;
      ptr       <= '0;
      gidx      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done      <= '0;
          count_out <= '0;
          if (req != '0) begin
            state <= S_RUN;
            gnt   <= win;
            busy  <= 1'b1;
            tlen  <= win_len;
            gidx  <= win_idx;
          end else begin
            gnt  <= '0;
            busy <= 1'b0;
          end
        end

        S_RUN: begin
          if (!req[gidx]) begin
            // Abort takes priority over a completion in the same cycle.
            state     <= S_IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            count_out <= '0;
            ptr       <= ptr_next;
          end else if (count_out == tlen - CW'(1)) begin
            // tlen of 0 wraps to all ones, giving a full 2^CW-cycle run.
            state <= S_DONE;
            done  <= gnt;
          end else begin
            count_out <= count_out + CW'(1);
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          gnt       <= '0;
          done      <= '0;
          busy      <= 1'b0;
          count_out <= '0;
          ptr       <= ptr_next;
        end

        default: begin
          state     <= S_IDLE;
          gnt       <= '0;
          done      <= '0;
          busy      <= 1'b0;
          count_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
module tb_counter_scheduler;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] len;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [3:0]  count_out;
  logic [1:0]  state_dbg;

  int errors;
  int checks;

  counter_scheduler #(.NREQ(4), .CW(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .len       (len),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .count_out (count_out),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req = 4'b1111;
    len = 16'h2222;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({gnt, done, busy, count_out} !== 13'd0) begin
        errors++;
        $display("FAIL reset_hold: gnt=%b done=%b busy=%b count=%0d expected all 0", gnt, done, busy, count_out);
      end
    end
    req = 4'b0000;
    reset = 1'b0;
    tick();
    checks++;
    if ({gnt, done, busy, count_out} !== 13'd0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_after: gnt=%b done=%b busy=%b count=%0d state=%0d expected all 0", gnt, done, busy, count_out, state_dbg);
    end
  endtask

  task automatic test_single_run();
    req = 4'b0001;
    len = 16'h0005;
    tick();
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || count_out !== 4'd0 || done !== 4'b0000) begin
      errors++;
      $display("FAIL single_grant: gnt=%b busy=%b count=%0d done=%b expected 0001 1 0 0000", gnt, busy, count_out, done);
    end
    // Changing len mid-run must not affect the active run.
    len = 16'h0002;
    for (int i = 1; i < 5; i++) begin
      tick();
      checks++;
      if (count_out !== 4'(i) || done !== 4'b0000 || gnt !== 4'b0001) begin
        errors++;
        $display("FAIL single_count: count=%0d done=%b gnt=%b expected %0d 0000 0001", count_out, done, gnt, i);
      end
    end
    tick();
    checks++;
    if (done !== 4'b0001 || gnt !== 4'b0001 || busy !== 1'b1 || count_out !== 4'd4) begin
      errors++;
      $display("FAIL single_done: done=%b gnt=%b busy=%b count=%0d expected 0001 0001 1 4", done, gnt, busy, count_out);
    end
    req = 4'b0000;
    tick();
    checks++;
    if ({gnt, done, busy, count_out} !== 13'd0) begin
      errors++;
      $display("FAIL single_idle: gnt=%b done=%b busy=%b count=%0d expected all 0", gnt, done, busy, count_out);
    end
  endtask

  task automatic test_len_one();
    do_reset();
    req = 4'b0010;
    len = 16'h0010;
    tick();
    checks++;
    if (gnt !== 4'b0010 || count_out !== 4'd0 || done !== 4'b0000) begin
      errors++;
      $display("FAIL len1_run: gnt=%b count=%0d done=%b expected 0010 0 0000", gnt, count_out, done);
    end
    tick();
    checks++;
    if (done !== 4'b0010 || count_out !== 4'd0) begin
      errors++;
      $display("FAIL len1_done: done=%b count=%0d expected 0010 0", done, count_out);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    do_reset();
    req = 4'b1111;
    len = 16'h2222;
    for (int j = 0; j < 5; j++) begin
      exp_gnt = 4'b0001 << (j % 4);
      tick();
      checks++;
      if (gnt !== exp_gnt || count_out !== 4'd0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant%0d: gnt=%b count=%0d busy=%b expected %b 0 1", j, gnt, count_out, busy, exp_gnt);
      end
      tick();
      checks++;
      if (count_out !== 4'd1 || done !== 4'b0000) begin
        errors++;
        $display("FAIL rr_count%0d: count=%0d done=%b expected 1 0000", j, count_out, done);
      end
      tick();
      checks++;
      if (done !== exp_gnt || gnt !== exp_gnt) begin
        errors++;
        $display("FAIL rr_done%0d: done=%b gnt=%b expected %b", j, done, gnt, exp_gnt);
      end
      if (j == 4) req = 4'b0000;
      tick();
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000) begin
        errors++;
        $display("FAIL rr_idle%0d: gnt=%b busy=%b done=%b expected 0 0 0", j, gnt, busy, done);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b0100;
    len = 16'hF0FF;
    tick();
    checks++;
    if (gnt !== 4'b0100 || count_out !== 4'd0) begin
      errors++;
      $display("FAIL wrap_grant: gnt=%b count=%0d expected 0100 0", gnt, count_out);
    end
    for (int i = 1; i < 16; i++) begin
      tick();
      checks++;
      if (count_out !== 4'(i) || done !== 4'b0000) begin
        errors++;
        $display("FAIL wrap_count: count=%0d done=%b expected %0d 0000", count_out, done, i);
      end
    end
    tick();
    checks++;
    if (done !== 4'b0100 || count_out !== 4'd15) begin
      errors++;
      $display("FAIL wrap_done: done=%b count=%0d expected 0100 15", done, count_out);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (done !== 4'b0000 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL wrap_single_pulse: done=%b gnt=%b expected 0000 0000", done, gnt);
    end
  endtask

  // Pointer is 3 on entry (last served requester was 2).
  task automatic test_abort();
    req = 4'b0010;
    len = 16'h0080;
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL abort_grant: gnt=%b expected 0010", gnt);
    end
    tick();
    tick();
    tick();
    checks++;
    if (count_out !== 4'd3) begin
      errors++;
      $display("FAIL abort_pre: count=%0d expected 3", count_out);
    end
    req = 4'b0000;
    tick();
    checks++;
    if ({gnt, done, busy, count_out} !== 13'd0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL abort_idle: gnt=%b done=%b busy=%b count=%0d state=%0d expected all 0", gnt, done, busy, count_out, state_dbg);
    end
    req = 4'b0011;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL abort_next_grant: gnt=%b expected 0001", gnt);
    end
    req = 4'b0000;
    tick();
  endtask

  // Drop on the final count cycle: abort must beat completion.
  task automatic test_abort_last();
    do_reset();
    req = 4'b0001;
    len = 16'h0003;
    tick();
    tick();
    tick();
    checks++;
    if (count_out !== 4'd2) begin
      errors++;
      $display("FAIL abort_last_pre: count=%0d expected 2", count_out);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (done !== 4'b0000 || gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_last: done=%b gnt=%b busy=%b expected 0000 0000 0", done, gnt, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    req = 4'b1000;
    len = 16'hA000;
    tick();
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (count_out !== 4'd6 || gnt !== 4'b1000) begin
      errors++;
      $display("FAIL midrst_pre: count=%0d gnt=%b expected 6 1000", count_out, gnt);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({gnt, done, busy, count_out} !== 13'd0) begin
      errors++;
      $display("FAIL midrst_clear: gnt=%b done=%b busy=%b count=%0d expected all 0", gnt, done, busy, count_out);
    end
    tick();
    checks++;
    if (gnt !== 4'b0000 || done !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_hold: gnt=%b done=%b expected 0000 0000", gnt, done);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b1000 || count_out !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_regrant: gnt=%b count=%0d busy=%b expected 1000 0 1", gnt, count_out, busy);
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    req    = 4'b0000;
    len    = 16'h0000;
    test_reset();
    test_single_run();
    test_len_one();
    test_round_robin();
    test_wrap();
    test_abort();
    test_abort_last();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
